// File: rtl/cr_huf_comp_sc_mc.sv
// cr_huf_comp_sc_mc -- multi-channel symbol-count staging buffer.
//
// Per-channel flop FIFOs filled through one registered write port and
// drained through one show-ahead read port. A round-robin arbiter that
// locks its grant while the head is stalled merges the channels.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_wr/i_wr_ch/i_wr_data  write strobe, target channel, payload (registered)
//   o_wr_rdy          per-channel credit ready (free slots > RDY_THRESH)
//   i_ch_clear        per-channel synchronous flush
//   o_out_vld/i_out_rd/o_out_ch/o_out_data  read handshake and head entry
//   o_used_slots      per-channel occupancy, channel 0 in the LSBs
//   o_overflow_err    sticky: write dropped on a full channel
//   o_underflow_err   sticky: pop issued while o_out_vld was low
//   o_hwm             per-channel occupancy high-watermark
//                     (present only with CR_HUF_COMP_SC_MC_STATS_EN defined)
//
// Arbiter state:
//   state  | meaning
//   S_OPEN | grant searches upward from last_grant+1 each cycle
//   S_LOCK | head stalled, grant frozen on r_lock_ch until the pop
module cr_huf_comp_sc_mc #(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 16,
  parameter int DATA_W     = 15,
  parameter int RDY_THRESH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr,
  input  logic [CH_W-1:0]         i_wr_ch,
  input  logic [DATA_W-1:0]       i_wr_data,
  output logic [NUM_CH-1:0]       o_wr_rdy,
  input  logic [NUM_CH-1:0]       i_ch_clear,
  output logic                    o_out_vld,
  input  logic                    i_out_rd,
  output logic [CH_W-1:0]         o_out_ch,
  output logic [DATA_W-1:0]       o_out_data,
  output logic [NUM_CH*CNT_W-1:0] o_used_slots,
  output logic                    o_overflow_err,
  output logic                    o_underflow_err
`ifdef CR_HUF_COMP_SC_MC_STATS_EN
  ,output logic [NUM_CH*CNT_W-1:0] o_hwm
`endif
);

  typedef enum logic {S_OPEN, S_LOCK} arb_state_t;

  arb_state_t        r_state, w_state_nxt;
  logic [CH_W-1:0]   r_lock_ch, r_last;
  logic              r_wr;
  logic [CH_W-1:0]   r_wr_ch;
  logic [DATA_W-1:0] r_wr_data;
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
  logic [DATA_W-1:0] r_mem    [NUM_CH][DEPTH];

  logic [NUM_CH-1:0] w_nonempty;
  logic              w_vld, w_pop, w_pop_same, w_wr_ok, w_full, w_commit, w_drop;
  logic [CH_W-1:0]   w_srch, w_grant;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) w_nonempty[c] = (r_cnt[c] != '0);
  end
  assign w_vld = |w_nonempty;

  // Round-robin search starting just above the last granted channel.
  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    w_srch = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(r_last) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && w_nonempty[idx]) begin
        found  = 1'b1;
        w_srch = CH_W'(idx);
      end
    end
  end

  assign w_grant    = (r_state == S_LOCK) ? r_lock_ch : w_srch;
  assign o_out_vld  = w_vld;
  assign o_out_ch   = w_vld ? w_grant : '0;
  assign o_out_data = w_vld ? r_mem[w_grant][r_rd_ptr[w_grant]] : '0;

  assign w_pop      = w_vld && i_out_rd;
  assign w_pop_same = w_pop && (w_grant == r_wr_ch);
  // A clear on the target channel silently discards the registered write.
  assign w_wr_ok    = r_wr && !i_ch_clear[r_wr_ch];
  assign w_full     = (r_cnt[r_wr_ch] == CNT_W'(DEPTH));
  assign w_commit   = w_wr_ok && (!w_full || w_pop_same);
  assign w_drop     = w_wr_ok && w_full && !w_pop_same;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OPEN: if (w_vld && !i_out_rd) w_state_nxt = S_LOCK;
      S_LOCK: if (i_out_rd)           w_state_nxt = S_OPEN;
      default:                        w_state_nxt = S_OPEN;
    endcase
    if (i_ch_clear[w_grant]) w_state_nxt = S_OPEN;
  end

  always_comb begin
    o_used_slots = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_used_slots[c*CNT_W +: CNT_W] = r_cnt[c];
      o_wr_rdy[c] = (DEPTH - int'(r_cnt[c])) > RDY_THRESH;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_OPEN;
      r_lock_ch       <= '0;
      r_last          <= '0;
      r_wr            <= 1'b0;
      r_wr_ch         <= '0;
      r_wr_data       <= '0;
      o_overflow_err  <= 1'b0;
      o_underflow_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr      <= i_wr;
      r_wr_ch   <= i_wr_ch;
      r_wr_data <= i_wr_data;
      if (r_state == S_OPEN) r_lock_ch <= w_grant;
      if (w_pop) r_last <= w_grant;
      if (w_drop) o_overflow_err <= 1'b1;
      if (i_out_rd && !w_vld) o_underflow_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]    <= '0;
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_ch_clear[c]) begin
          r_cnt[c]    <= '0;
          r_rd_ptr[c] <= '0;
          r_wr_ptr[c] <= '0;
        end else begin
          logic inc, dec;
          inc = w_commit && (r_wr_ch == CH_W'(c));
          dec = w_pop && (w_grant == CH_W'(c));
          if (inc) r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
          if (dec) r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
          if (inc && !dec)      r_cnt[c] <= r_cnt[c] + CNT_W'(1);
          else if (dec && !inc) r_cnt[c] <= r_cnt[c] - CNT_W'(1);
        end
      end
    end
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_commit) r_mem[r_wr_ch][r_wr_ptr[r_wr_ch]] <= r_wr_data;
  end

`ifdef CR_HUF_COMP_SC_MC_STATS_EN
  logic [CNT_W-1:0] r_hwm [NUM_CH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) r_hwm[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_ch_clear[c])          r_hwm[c] <= '0;
        else if (r_cnt[c] > r_hwm[c]) r_hwm[c] <= r_cnt[c];
      end
    end
  end

  always_comb begin
    o_hwm = '0;
    for (int c = 0; c < NUM_CH; c++) o_hwm[c*CNT_W +: CNT_W] = r_hwm[c];
  end
`endif

endmodule

// File: tb/tb_cr_huf_comp_sc_mc.sv
module tb_cr_huf_comp_sc_mc;
  localparam int NUM_CH     = 2;
  localparam int DEPTH      = 16;
  localparam int DATA_W     = 15;
  localparam int RDY_THRESH = 4;
  localparam int CW         = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr;
  logic [0:0]              wr_ch;
  logic [DATA_W-1:0]       wr_data;
  logic [NUM_CH-1:0]       wr_rdy;
  logic [NUM_CH-1:0]       ch_clear;
  logic                    out_vld;
  logic                    out_rd;
  logic [0:0]              out_ch;
  logic [DATA_W-1:0]       out_data;
  logic [NUM_CH*CW-1:0]    used_slots;
  logic                    overflow_err;
  logic                    underflow_err;
`ifdef CR_HUF_COMP_SC_MC_STATS_EN
  logic [NUM_CH*CW-1:0]    hwm;
`endif

  always #5 clk = ~clk;

  cr_huf_comp_sc_mc #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .RDY_THRESH(RDY_THRESH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_wr_ch(wr_ch), .i_wr_data(wr_data),
    .o_wr_rdy(wr_rdy), .i_ch_clear(ch_clear), .o_out_vld(out_vld),
    .i_out_rd(out_rd), .o_out_ch(out_ch), .o_out_data(out_data),
    .o_used_slots(used_slots), .o_overflow_err(overflow_err),
    .o_underflow_err(underflow_err)
`ifdef CR_HUF_COMP_SC_MC_STATS_EN
    , .o_hwm(hwm)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of expected payloads per channel, plus the
  // write that is waiting in the input register.
  logic [DATA_W-1:0] mq [NUM_CH][$];
  bit                m_lock, m_ovf, m_unf, p_wr;
  int                m_lock_ch, m_last, p_ch;
  logic [DATA_W-1:0] p_data;

  function automatic bit m_vld();
    for (int c = 0; c < NUM_CH; c++) if (mq[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_grant();
    if (m_lock) return m_lock_ch;
    for (int i = 1; i <= NUM_CH; i++)
      if (mq[(m_last + i) % NUM_CH].size() != 0) return (m_last + i) % NUM_CH;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_lock = 0; m_ovf = 0; m_unf = 0; p_wr = 0;
      m_lock_ch = 0; m_last = 0; p_ch = 0; p_data = '0;
    end else begin
      bit v, pop;
      int g, pre;
      v   = m_vld();
      g   = m_grant();
      pop = v && out_rd;
      pre = mq[p_ch].size();
      if (pop && !ch_clear[g]) void'(mq[g].pop_front());
      if (p_wr && !ch_clear[p_ch]) begin
        if (pre < DEPTH || (pop && g == p_ch)) mq[p_ch].push_back(p_data);
        else m_ovf = 1;
      end
      for (int c = 0; c < NUM_CH; c++) if (ch_clear[c]) mq[c].delete();
      if (out_rd && !v) m_unf = 1;
      if (pop) begin m_last = g; m_lock = 0; end
      else if (v) begin m_lock = 1; m_lock_ch = g; end
      if (ch_clear[g]) m_lock = 0;
      p_wr = wr; p_ch = int'(wr_ch); p_data = wr_data;
    end
  end

  // Monitor: compares every visible output against the model mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      bit v;
      int g;
      v = m_vld();
      g = m_grant();
      chk("out_vld", 32'(out_vld), 32'(v));
      if (v) begin
        chk("out_ch", 32'(out_ch), 32'(g));
        chk("out_data", 32'(out_data), 32'(mq[g][0]));
      end else begin
        chk("out_ch_idle", 32'(out_ch), 32'd0);
        chk("out_data_idle", 32'(out_data), 32'd0);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        chk("used_slots", 32'(used_slots[c*CW +: CW]), 32'(mq[c].size()));
        chk("wr_rdy", 32'(wr_rdy[c]), 32'((DEPTH - mq[c].size()) > RDY_THRESH));
      end
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
      chk("underflow_err", 32'(underflow_err), 32'(m_unf));
    end
  end

  task automatic drive(input bit w, input int ch, input logic [DATA_W-1:0] d,
                       input bit rd, input logic [NUM_CH-1:0] clr);
    wr = w; wr_ch = ch[0]; wr_data = d; out_rd = rd; ch_clear = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) drive(0, 0, '0, rd, '0);
  endtask

  task automatic rnd_data(output logic [DATA_W-1:0] d);
    d = DATA_W'($urandom);
  endtask

  task automatic reset_and_check();
    rst = 1'b1;
    wr = 0; wr_ch = 0; wr_data = '0; out_rd = 0; ch_clear = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_rdy", 32'(wr_rdy), 32'h3);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_used", 32'(used_slots), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    chk("rst_unf", 32'(underflow_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    reset_and_check();
    idle(2, 0);

    // Three writes to ch1 with the reader always ready.
    for (int i = 0; i < 3; i++) begin rnd_data(d); drive(1, 1, d, 1, '0); end
    idle(6, 1);

    // Fill ch0 past full with no reads; the 17th write is dropped.
    for (int i = 0; i < 17; i++) begin rnd_data(d); drive(1, 0, d, 0, '0); end
    idle(3, 0);
    idle(20, 1);

    // Four entries on each channel, then continuous reads.
    for (int i = 0; i < 8; i++) begin rnd_data(d); drive(1, i % 2, d, 0, '0); end
    idle(2, 0);
    idle(12, 1);

    // ch0 stalled at the head while ch1 fills, then drained.
    rnd_data(d); drive(1, 0, d, 0, '0);
    idle(2, 0);
    for (int i = 0; i < 5; i++) begin rnd_data(d); drive(1, 1, d, 0, '0); end
    idle(8, 1);

    // Full ch0: registered write commits alongside a pop on ch0.
    for (int i = 0; i < 16; i++) begin rnd_data(d); drive(1, 0, d, 0, '0); end
    idle(2, 0);
    rnd_data(d); drive(1, 0, d, 0, '0);
    drive(0, 0, '0, 1, '0);
    idle(2, 0);
    // Clear ch0 against both an in-flight and a concurrent write.
    rnd_data(d); drive(1, 0, d, 0, '0);
    rnd_data(d); drive(1, 0, d, 0, 2'b01);
    idle(3, 0);
    idle(4, 1);

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      bit w, rd;
      logic [NUM_CH-1:0] clr;
      if (i == 1000) reset_and_check();
      w   = ($urandom_range(0, 2) != 0);
      rd  = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0) ? NUM_CH'($urandom_range(1, 3)) : '0;
      rnd_data(d);
      drive(w, int'($urandom_range(0, 1)), d, rd, clr);
    end

    // Drain, then pop on empty channels to raise the underflow flag.
    idle(40, 1);
    idle(3, 0);
    reset_and_check();
    idle(2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
